// File: rtl/cpu_path_loader.sv
// cpu_path_loader: loads start/end nodes into CPU data memory, runs the CPU, streams its path result.
module cpu_path_loader #(
  parameter logic [31:0] START_ADR   = 32'h0200_0000,
  parameter logic [31:0] END_ADR     = 32'h0200_0004,
  parameter logic [31:0] CPU_TIMEOUT = 32'd2_000_000,
  parameter int          MAX_NODES   = 13
) (
  input  logic                   adc_sck,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             start_node,
  input  logic [7:0]             end_node,
  output logic                   cpu_rst_o,
  output logic                   mem_clr,
  output logic                   Ext_MemWrite,
  output logic [31:0]            Ext_DataAdr,
  output logic [31:0]            Ext_WriteData,
  input  logic                   cpu_done,
  input  logic [8*MAX_NODES-1:0] path_flat,
  input  logic [7:0]             index_in,
  output logic                   node_valid,
  output logic [7:0]             node_data,
  output logic                   node_last,
  input  logic                   node_ready,
  output logic                   err
);
  typedef enum logic [2:0] {IDLE, CLR, WR_S, WR_E, RUN, CAPT, STREAM, ERR} state_t;
  localparam logic [7:0] MAXN = 8'(MAX_NODES);
  state_t state_q, state_d;
  logic [7:0] start_q, start_d, end_q, end_d, len_q, len_d, ptr_q, ptr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [8*MAX_NODES-1:0] path_q, path_d;
  always_ff @(posedge adc_sck or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= '0;
      end_q   <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      path_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      path_q  <= path_d;
    end
  end
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    end_d   = end_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    path_d  = path_q;
    case (state_q)
      IDLE: if (req_valid) begin
        start_d = start_node;
        end_d   = end_node;
        state_d = CLR;
      end
      CLR:  state_d = WR_S;
      WR_S: state_d = WR_E;
      WR_E: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      // done on the first RUN cycle is stale and ignored; done beats timeout
      RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (cpu_done && cnt_q != '0) state_d = CAPT;
        else if (cnt_q == CPU_TIMEOUT - 32'd1) state_d = ERR;
      end
      CAPT: begin
        path_d  = path_flat;
        len_d   = index_in;
        ptr_d   = '0;
        state_d = (index_in == '0 || index_in > MAXN) ? ERR : STREAM;
      end
      STREAM: if (node_ready) begin
        ptr_d = ptr_q + 8'd1;
        if (ptr_q == len_q - 8'd1) state_d = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign req_ready     = state_q == IDLE;
  assign cpu_rst_o     = state_q != RUN;
  assign mem_clr       = state_q == CLR;
  assign Ext_MemWrite  = state_q == WR_S || state_q == WR_E;
  assign Ext_DataAdr   = state_q == WR_S ? START_ADR : state_q == WR_E ? END_ADR : '0;
  assign Ext_WriteData = state_q == WR_S ? {24'b0, start_q} : state_q == WR_E ? {24'b0, end_q} : '0;
  assign node_valid    = state_q == STREAM;
  assign node_data     = node_valid ? path_q[{ptr_q, 3'b000} +: 8] : '0;
  assign node_last     = node_valid && ptr_q == len_q - 8'd1;
  assign err           = state_q == ERR;
endmodule

// File: tb/tb_cpu_path_loader.sv
// tb_cpu_path_loader: directed stimulus, cycle model compared every cycle, plus literal expectations.
module tb_cpu_path_loader;
  localparam logic [31:0] SA = 32'h0200_0000, EA = 32'h0200_0004;
  localparam int TO = 200, MAXN = 13;
  localparam int M_IDLE = 0, M_SETUP = 1, M_RUN = 2, M_CAPT = 3, M_STREAM = 4, M_ERR = 5;
  logic adc_sck = 0, reset = 1, req_valid = 0, cpu_done = 0, node_ready = 0, req_t = 0;
  logic [7:0] start_node = 0, end_node = 0, index_in = 0;
  logic [8*MAXN-1:0] path_flat = '0;
  logic req_ready, cpu_rst_o, mem_clr, Ext_MemWrite, node_valid, node_last, err;
  logic [31:0] Ext_DataAdr, Ext_WriteData;
  logic [7:0] node_data;
  logic t_req_ready, t_cpu_rst, t_mem_clr, t_we, t_node_valid, t_node_last, t_err;
  logic [31:0] t_adr, t_wd;
  logic [7:0] t_node_data;
  int checks = 0, errors = 0;
  int cyc = 0, clr_c = 0, wr_c = 0, clr_n = 0, err_n = 0, t_nv = 0;
  logic [63:0] ext_log[$];
  logic [7:0] rx[$];
  logic rx_last[$];
  int mode = M_IDLE, t = 0, run_n = 0;
  logic [7:0] ms = 0, me = 0;
  logic [7:0] mq[$];
  always #5 adc_sck = ~adc_sck;
  cpu_path_loader #(.CPU_TIMEOUT(32'(TO))) dut (
    .adc_sck(adc_sck), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .start_node(start_node), .end_node(end_node), .cpu_rst_o(cpu_rst_o), .mem_clr(mem_clr),
    .Ext_MemWrite(Ext_MemWrite), .Ext_DataAdr(Ext_DataAdr), .Ext_WriteData(Ext_WriteData),
    .cpu_done(cpu_done), .path_flat(path_flat), .index_in(index_in), .node_valid(node_valid),
    .node_data(node_data), .node_last(node_last), .node_ready(node_ready), .err(err));
  cpu_path_loader #(.CPU_TIMEOUT(32'd16)) dut_t (
    .adc_sck(adc_sck), .reset(reset), .req_valid(req_t), .req_ready(t_req_ready),
    .start_node(start_node), .end_node(end_node), .cpu_rst_o(t_cpu_rst), .mem_clr(t_mem_clr),
    .Ext_MemWrite(t_we), .Ext_DataAdr(t_adr), .Ext_WriteData(t_wd),
    .cpu_done(1'b0), .path_flat(path_flat), .index_in(index_in), .node_valid(t_node_valid),
    .node_data(t_node_data), .node_last(t_node_last), .node_ready(1'b1), .err(t_err));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired", name);
  endtask
  // Behavioural model: a request runs a 3-cycle setup, RUN, capture, then drains a node queue.
  always @(posedge adc_sck or posedge reset) begin
    if (reset) begin
      mode = M_IDLE;
      mq.delete();
    end else begin
      case (mode)
        M_IDLE: if (req_valid) begin
          ms = start_node;
          me = end_node;
          t = 0;
          mode = M_SETUP;
        end
        M_SETUP: begin
          t++;
          if (t == 3) begin
            mode = M_RUN;
            run_n = 0;
          end
        end
        M_RUN: begin
          if (run_n > 0 && cpu_done) mode = M_CAPT;
          else if (run_n == TO - 1) mode = M_ERR;
          run_n++;
        end
        M_CAPT: begin
          if (index_in == 0 || index_in > MAXN) mode = M_ERR;
          else begin
            mq.delete();
            for (int i = 0; i < int'(index_in); i++) mq.push_back(path_flat[i*8 +: 8]);
            mode = M_STREAM;
          end
        end
        M_STREAM: if (node_ready) begin
          void'(mq.pop_front());
          if (mq.size() == 0) mode = M_IDLE;
        end
        default: mode = M_IDLE;
      endcase
    end
  end
  always @(negedge adc_sck) begin
    logic we;
    we = mode == M_SETUP && t > 0;
    chk("req_ready", req_ready, mode == M_IDLE);
    chk("cpu_rst_o", cpu_rst_o, mode != M_RUN);
    chk("mem_clr", mem_clr, mode == M_SETUP && t == 0);
    chk("Ext_MemWrite", Ext_MemWrite, we);
    chk("Ext_DataAdr", Ext_DataAdr, we ? (t == 1 ? SA : EA) : 32'd0);
    chk("Ext_WriteData", Ext_WriteData, we ? {24'b0, t == 1 ? ms : me} : 32'd0);
    chk("node_valid", node_valid, mode == M_STREAM);
    chk("node_data", node_data, mode == M_STREAM ? mq[0] : 8'd0);
    chk("node_last", node_last, mode == M_STREAM && mq.size() == 1);
    chk("err", err, mode == M_ERR);
  end
  always @(posedge adc_sck) begin
    cyc++;
    if (mem_clr) begin
      clr_c = cyc;
      clr_n++;
    end
    if (Ext_MemWrite) ext_log.push_back({Ext_DataAdr, Ext_WriteData});
    if (Ext_MemWrite && Ext_DataAdr == SA) wr_c = cyc;
    if (node_valid && node_ready) begin
      rx.push_back(node_data);
      rx_last.push_back(node_last);
    end
    if (err) err_n++;
    if (t_node_valid) t_nv++;
  end
  task automatic request(input logic [7:0] s, input logic [7:0] e);
    @(negedge adc_sck);
    start_node = s;
    end_node = e;
    req_valid = 1;
    @(negedge adc_sck);
    req_valid = 0;
  endtask
  // Stale done on the first RUN cycle plus a busy request, then real done after dly cycles.
  task automatic run_cpu(input int dly);
    int k;
    k = 0;
    while (cpu_rst_o !== 1'b0 && k < 20) begin
      @(negedge adc_sck);
      k++;
    end
    if (k >= 20) fail_now("release");
    cpu_done = 1;
    start_node = 5;
    req_valid = 1;
    @(negedge adc_sck);
    cpu_done = 0;
    req_valid = 0;
    chk("stale_done_ignored", cpu_rst_o, 0);
    repeat (dly - 1) @(negedge adc_sck);
    cpu_done = 1;
    @(negedge adc_sck);
    cpu_done = 0;
  endtask
  task automatic wait_idle(input logic [3:0] pat);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 100) begin
      node_ready = pat[k % 4];
      @(negedge adc_sck);
      k++;
    end
    if (k >= 100) fail_now("idle");
    node_ready = 1;
  endtask
  task automatic check_stream();
    logic [7:0] exp_rx[4];
    exp_rx = '{8'd3, 8'd7, 8'd9, 8'd11};
    chk("rx_count", rx.size(), 4);
    for (int i = 0; i < 4 && i < rx.size(); i++) begin
      chk("rx_node", rx[i], exp_rx[i]);
      chk("rx_last", rx_last[i], i == 3);
    end
    rx.delete();
    rx_last.delete();
  endtask
  initial begin
    int k, n, e0;
    repeat (2) @(negedge adc_sck);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_cpu_rst", cpu_rst_o, 1);
    chk("rst_mem_clr", mem_clr, 0);
    chk("rst_we", Ext_MemWrite, 0);
    chk("rst_adr", Ext_DataAdr, 0);
    chk("rst_wd", Ext_WriteData, 0);
    chk("rst_nv", node_valid, 0);
    chk("rst_nd", node_data, 0);
    chk("rst_nl", node_last, 0);
    chk("rst_err", err, 0);
    reset = 0;
    for (int i = 0; i < MAXN; i++) path_flat[i*8 +: 8] = 8'hEE;
    path_flat[31:0] = {8'd11, 8'd9, 8'd7, 8'd3};
    index_in = 4;
    node_ready = 1;
    // nominal
    ext_log.delete();
    request(3, 11);
    run_cpu(50);
    wait_idle(4'b1111);
    repeat (3) @(negedge adc_sck);
    chk("ext_count", ext_log.size(), 2);
    chk("ext0_adr", ext_log[0][63:32], SA);
    chk("ext0_data", ext_log[0][31:0], 3);
    chk("ext1_adr", ext_log[1][63:32], EA);
    chk("ext1_data", ext_log[1][31:0], 11);
    chk("clr_before_wr", wr_c - clr_c, 1);
    chk("busy_req_ignored", clr_n, 1);
    chk("req_ready_back", req_ready, 1);
    check_stream();
    // backpressure
    request(3, 11);
    run_cpu(50);
    wait_idle(4'b1001);
    check_stream();
    // bad lengths
    foreach (index_in[i]) ;
    index_in = 0;
    e0 = err_n;
    request(3, 11);
    run_cpu(10);
    wait_idle(4'b1111);
    chk("badlen0_err", err_n - e0, 1);
    chk("badlen0_rx", rx.size(), 0);
    index_in = 14;
    e0 = err_n;
    request(3, 11);
    run_cpu(10);
    wait_idle(4'b1111);
    chk("badlen14_err", err_n - e0, 1);
    chk("badlen14_rx", rx.size(), 0);
    index_in = 4;
    // reset during RUN
    request(3, 11);
    k = 0;
    while (cpu_rst_o !== 1'b0 && k < 20) begin
      @(negedge adc_sck);
      k++;
    end
    if (k >= 20) fail_now("release_rr");
    repeat (5) @(negedge adc_sck);
    #2 reset = 1;
    #1;
    chk("arst_run_cpu_rst", cpu_rst_o, 1);
    chk("arst_run_req_ready", req_ready, 1);
    chk("arst_run_we", Ext_MemWrite, 0);
    @(negedge adc_sck);
    reset = 0;
    // reset during STREAM
    node_ready = 0;
    request(3, 11);
    run_cpu(20);
    repeat (2) @(negedge adc_sck);
    chk("stall_nv", node_valid, 1);
    chk("stall_nd", node_data, 3);
    #2 reset = 1;
    #1;
    chk("arst_st_nv", node_valid, 0);
    chk("arst_st_nd", node_data, 0);
    chk("arst_st_cpu_rst", cpu_rst_o, 1);
    @(negedge adc_sck);
    reset = 0;
    chk("arst_st_rx", rx.size(), 0);
    node_ready = 1;
    request(3, 11);
    run_cpu(30);
    wait_idle(4'b1111);
    check_stream();
    // timeout on the CPU_TIMEOUT=16 instance
    @(negedge adc_sck);
    req_t = 1;
    @(negedge adc_sck);
    req_t = 0;
    k = 0;
    while (t_cpu_rst !== 1'b0 && k < 20) begin
      @(negedge adc_sck);
      k++;
    end
    if (k >= 20) fail_now("release_to");
    n = 0;
    while (t_err !== 1'b1 && n < 40) begin
      @(negedge adc_sck);
      n++;
    end
    chk("timeout_cycles", n, 16);
    chk("timeout_cpu_rst", t_cpu_rst, 1);
    @(negedge adc_sck);
    chk("timeout_err_pulse", t_err, 0);
    chk("timeout_idle", t_req_ready, 1);
    chk("timeout_no_nodes", t_nv, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
